writeback_stage: RTL

//  MEM/WB pipeline register plus writeback select feeding the register file's write port (pos, writevalue).

---
 rtl/writeback_stage.sv | 73 +++++++
 1 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register with writeback select, forwarding tap and retire counter.
// Define WB_LOAD_EXT_EN for little-endian sub-word load extraction.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter logic [REG_ADDR_W-1:0] NOWRITE_POS = 5'h1F
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_regwrite,
  input  logic                  in_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic                  stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] pos,
  output logic [DATA_W-1:0]     writevalue,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_value,
  output logic [31:0]           retired,
  output logic                  r31_drop
);
  logic                  take, valid_q, wr_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     value_q, load;
  assign in_ready = !stall;
  assign take = in_valid && !stall && !flush;
`ifdef WB_LOAD_EXT_EN
  logic [DATA_W-1:0] shifted;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  always_comb begin
    shifted = in_mem_data >> {in_alu_result[1:0], 3'b000};
    byte_v = shifted[7:0];
    half_v = in_alu_result[1] ? in_mem_data[31:16] : in_mem_data[15:0];
    load = in_ld_size == 2'b00 ? {{(DATA_W-8){~in_ld_unsigned & byte_v[7]}}, byte_v} :
           in_ld_size == 2'b01 ? {{(DATA_W-16){~in_ld_unsigned & half_v[15]}}, half_v} :
           in_mem_data;
  end
`else
  logic unused_ld;
  assign unused_ld = ^{in_ld_size, in_ld_unsigned};
  assign load = in_mem_data;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      wr_q     <= 1'b0;
      dest_q   <= '0;
      value_q  <= '0;
      retired  <= '0;
      r31_drop <= 1'b0;
    end else begin
      valid_q <= take;
      wr_q    <= take && in_regwrite && in_dest != '0 && in_dest != '1;
      dest_q  <= in_dest;
      value_q <= in_mem_to_reg ? load : in_alu_result;
      if (valid_q) retired <= retired + 32'd1;
      if (take && in_regwrite && in_dest == '1) r31_drop <= 1'b1;
    end
  end
  assign pos        = wr_q ? dest_q : NOWRITE_POS;
  assign writevalue = valid_q ? value_q : '0;
  assign fwd_valid  = pos != NOWRITE_POS;
  assign fwd_dest   = fwd_valid ? pos : '0;
  assign fwd_value  = writevalue;
endmodule
